// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between NUM_REQ writeback
// requesters (ALU, load unit, multiplier, branch-link, ...). Requesters are
// served round-robin. The winner's destination address is decoded into a
// one-hot 32-bit write enable and presented through one registered output
// stage. Writes to ZERO_REG consume a grant but never produce a write enable.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-low reset
//   req_valid  in   [NUM_REQ]            per-requester pending write
//   req_addr   in   [5*NUM_REQ]          destination register, slice i = [5i+4:5i]
//   req_data   in   [DATA_WIDTH*NUM_REQ] write data, sliced per requester
//   req_ready  out  [NUM_REQ]            combinational one-hot grant
//   rf_busy    in   register file cannot accept a write this cycle
//   wr_en      out  [32]                 registered one-hot write enable
//   wr_addr    out  [5]                  registered write address
//   wr_data    out  [DATA_WIDTH]         registered write data
//   wr_valid   out  registered write strobe, equals |wr_en
//   grant_id   out  [3]                  requester that produced the wr_* contents
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [5*NUM_REQ-1:0]          req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rf_busy,
  output logic [31:0]                   wr_en,
  output logic [4:0]                    wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_valid,
  output logic [2:0]                    grant_id
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------------------------------------------------------------------
  // Per-requester views of the flattened address/data buses
  // ---------------------------------------------------------------------------
  logic [4:0]            addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[5*gi +: 5];
    assign data_arr[gi] = req_data[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [31:0]           wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [2:0]            grant_id_q, grant_id_d;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester starting at rr_ptr_q
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] cand;
  logic [PtrW-1:0] grant_idx;
  logic            grant_found;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PtrW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A grant is only offered when the register file can take it and the block
  // is out of reset; req_ready is therefore also the transfer condition.
  logic grant_active;
  assign grant_active = grant_found && !rf_busy && reset;

  always_comb begin
    req_ready = '0;
    if (grant_active) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection and address decode
  // ---------------------------------------------------------------------------
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_is_zero;

  assign sel_addr    = addr_arr[grant_idx];
  assign sel_data    = data_arr[grant_idx];
  assign sel_is_zero = (sel_addr == 5'(ZERO_REG));

  // ---------------------------------------------------------------------------
  // Next-state for the output stage and the priority pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q;
    grant_id_d = grant_id_q;

    // While rf_busy is high everything holds so the presented write stays
    // visible to the register file until it is taken.
    if (!rf_busy) begin
      if (grant_active) begin
        wr_addr_d  = sel_addr;
        wr_data_d  = sel_data;
        grant_id_d = 3'(grant_idx);
        wr_en_d    = sel_is_zero ? 32'd0 : (32'd1 << sel_addr);
        wr_valid_d = !sel_is_zero;
        rr_ptr_d   = PtrW'((32'(grant_idx) + 32'd1) % NUM_REQ);
      end else begin
        wr_en_d    = '0;
        wr_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      grant_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign grant_id = grant_id_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_ready_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(req_ready));

  a_valid_is_en : assert property (@(posedge clk) disable iff (!reset)
    wr_valid == (|wr_en));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback requesters, e.g. ALU, load unit, multiplier and branch-link.
- Requesters are served round-robin. The winning address is decoded into a one-hot 32-bit write-enable bus for the register file.
- Sits between the execute/memory writeback stages and the register file. It has one registered output stage.
- Writes to the zero register (X31) are consumed and silently dropped.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- DATA_WIDTH, 64, width of the write data.
- ZERO_REG, 31, register index whose writes are discarded.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i set = requester i holds a pending write.
- req_addr  input  5*NUM_REQ  destination register; slice i = bits [5i+4:5i].
- req_data  input  DATA_WIDTH*NUM_REQ  write data, sliced per requester.
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- rf_busy  input  1  register file cannot accept a write this cycle.
- wr_en  output  32  one-hot decoded write enable to the register file.
- wr_addr  output  5  registered write address.
- wr_data  output  DATA_WIDTH  registered write data.
- wr_valid  output  1  registered write strobe; equals |wr_en.
- grant_id  output  3  index of the requester that produced the current wr_* contents.

Behaviour:
- Reset (reset=0, asynchronous): wr_en=0, wr_addr=0, wr_data=0, wr_valid=0, grant_id=0, rr_ptr=0. req_ready is combinational and is 0 while reset is asserted.
- rr_ptr (log2 NUM_REQ bits) names the highest-priority requester. Priority order: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
- req_ready is combinational. It is the one-hot of the first valid requester in priority order, gated by ~rf_busy. At most one bit is set. All bits are 0 when no request is valid or rf_busy=1.
- Transfer: on a clk edge where the granted req_valid & req_ready holds for requester g:
  - wr_addr <= req_addr[g], wr_data <= req_data[g], grant_id <= g.
  - wr_en <= decode(req_addr[g]) unless req_addr[g]==ZERO_REG, in which case wr_en <= 0.
  - wr_valid <= 1 unless the address is ZERO_REG.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly one cycle from an accepted request to wr_en at the register file. Throughput is one write per cycle.
- Idle: on an edge with no transfer and rf_busy=0, wr_en<=0 and wr_valid<=0. wr_addr, wr_data and grant_id hold.
- Busy: while rf_busy=1, all output registers hold, no transfer occurs, and rr_ptr holds. A write presented on wr_* remains presented, so the register file sees it until it deasserts rf_busy; this is the hold-on-stall rule.
- Zero-register write: still consumes a grant and advances rr_ptr, but never produces a wr_en bit.
- Address decode uses the standard 5-to-32 decoder enabled by the "not zero-reg" condition.
- No address-collision merging: two requesters targeting the same register are written in successive cycles in round-robin order, and the last write wins.
- A requester deasserting req_valid without a grant is legal. No state changes.
- Reset asserted mid-stream: the in-flight output is discarded and rr_ptr returns to 0 immediately.
- grant_id is zero-extended to 3 bits when NUM_REQ<8.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no valids.
  - Required: wr_en=0 and wr_valid=0 every cycle; req_ready=0.
- Single write: req0 writes addr=5, data=0xDEADBEEF.
  - Required: req_ready=0001 the same cycle.
  - Next cycle: wr_en=0x00000020, wr_addr=5, wr_data=0xDEADBEEF, grant_id=0.
  - Following cycle: wr_en=0.
- Round-robin fairness: all four valid continuously with addrs 1,2,3,4.
  - Required: grants 0,1,2,3,0,1,... one per cycle; wr_en sequence 0x2, 0x4, 0x8, 0x10, 0x2, ...
- Pointer wrap: after granting req3, only req1 and req2 are valid.
  - Required: req1 is granted first (ptr=0), then req2.
- Zero-register drop: req2 writes addr=31 while req3 writes addr=7.
  - Required: cycle 1 grants req2 and the next cycle shows wr_en=0, wr_valid=0.
  - Cycle 2 grants req3 and the next cycle shows wr_en=0x80.
- Stall and reset: req1 (addr=9) is accepted, then rf_busy=1 for 3 cycles with req0 valid.
  - Required: wr_en=0x200 is held for all 3 cycles and req_ready=0; req0 is granted in the first cycle after rf_busy falls.
  - Asserting reset mid-stall clears wr_en=0 immediately.
